// File: rtl/traffic_ctrl_multi_pkg.sv
// traffic_pkg: shared types and defaults for the NS/EW signal controller.
//   phase_t      - controller state, encodings are visible on the phase port
//   lamp_t       - one approach's lamp vector {green, yellow, red}
//   lamp_pair_t  - both approaches {ns, ew}
//   decode_lamps - lamp pattern for a phase (blink only matters in FLASH)
//   next_phase   - normal rotation order
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    RED_A     = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    RED_B     = 3'd5,
    FLASH     = 3'd6
  } phase_t;

  typedef struct packed {
    logic green;
    logic yellow;
    logic red;
  } lamp_t;

  typedef struct packed {
    lamp_t ns;
    lamp_t ew;
  } lamp_pair_t;

  localparam int DEF_CNT_W    = 8;
  localparam int DEF_GREEN_NS = 10;
  localparam int DEF_GREEN_EW = 10;
  localparam int DEF_YELLOW   = 3;
  localparam int DEF_ALL_RED  = 1;
  localparam int DEF_EXT_STEP = 5;
  localparam int DEF_EXT_MAX  = 10;

  function automatic lamp_pair_t decode_lamps(phase_t p, logic blink);
    lamp_pair_t l;
    l = '0;
    case (p)
      NS_GREEN:     begin l.ns.green  = 1'b1; l.ew.red = 1'b1; end
      NS_YELLOW:    begin l.ns.yellow = 1'b1; l.ew.red = 1'b1; end
      EW_GREEN:     begin l.ns.red = 1'b1; l.ew.green  = 1'b1; end
      EW_YELLOW:    begin l.ns.red = 1'b1; l.ew.yellow = 1'b1; end
      FLASH:        begin l.ns.yellow = blink; l.ew.red = blink; end
      default:      begin l.ns.red = 1'b1; l.ew.red = 1'b1; end
    endcase
    return l;
  endfunction

  function automatic phase_t next_phase(phase_t p);
    case (p)
      NS_GREEN:  return NS_YELLOW;
      NS_YELLOW: return RED_A;
      RED_A:     return EW_GREEN;
      EW_GREEN:  return EW_YELLOW;
      EW_YELLOW: return RED_B;
      default:   return NS_GREEN;
    endcase
  endfunction

endpackage

// File: rtl/traffic_ctrl_multi_phase_timer.sv
// phase_timer: remaining-ticks-minus-one counter for the current phase.
//   clk, reset  - clock, asynchronous active-high reset (loads RST_VAL)
//   tick        - timing strobe; the counter only moves when tick=1
//   load        - load load_val (takes priority over ext)
//   ext, grant  - extend: timer <= timer - 1 + grant (grant >= 1)
//   timer, zero - current count and timer==0 flag
module phase_timer #(
  parameter int              CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             ext,
  input  logic [CNT_W-1:0] grant,
  output logic [CNT_W-1:0] timer,
  output logic             zero
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= RST_VAL;
    end else if (tick) begin
      if (load)
        timer <= load_val;
      else if (ext)
        // Also correct at timer==0: 0 - 1 + grant wraps back to grant - 1.
        timer <= timer + grant - CNT_W'(1);
      else if (timer != '0)
        timer <= timer - CNT_W'(1);
    end
  end

  assign zero = (timer == '0);

endmodule

// File: rtl/traffic_ctrl_multi.sv
// traffic_ctrl_multi: two-approach (NS/EW) signal controller with capped
// green extension, all-red clearance and a flash (night/fault) mode.
//   clk, reset           - clock, asynchronous active-high reset
//   tick                 - timing strobe; state only changes on ticks
//   ns_ext, ew_ext       - green extension requests for each approach
//   flash_req            - level request for flash mode
//   ns_*/ew_* lamps      - registered lamp drives
//   phase                - current phase_t encoding
//   timer                - remaining ticks in phase minus one
//   cycle_start          - one-clk pulse on every entry to NS_GREEN
module traffic_ctrl_multi
  import traffic_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int GREEN_NS = DEF_GREEN_NS,
  parameter int GREEN_EW = DEF_GREEN_EW,
  parameter int YELLOW   = DEF_YELLOW,
  parameter int ALL_RED  = DEF_ALL_RED,
  parameter int EXT_STEP = DEF_EXT_STEP,
  parameter int EXT_MAX  = DEF_EXT_MAX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             ns_ext,
  input  logic             ew_ext,
  input  logic             flash_req,
  output logic             ns_green,
  output logic             ns_yellow,
  output logic             ns_red,
  output logic             ew_green,
  output logic             ew_yellow,
  output logic             ew_red,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] timer,
  output logic             cycle_start
);

  localparam int GREEN_MAX = (GREEN_NS > GREEN_EW) ? GREEN_NS : GREEN_EW;

  if (GREEN_NS < 1 || GREEN_EW < 1 || YELLOW < 1 || ALL_RED < 1 || EXT_STEP < 1)
  begin : g_bad_duration
    $error("traffic_ctrl_multi: all durations and EXT_STEP must be >= 1");
  end
  if (longint'(GREEN_MAX + EXT_MAX) > (longint'(1) << CNT_W)) begin : g_bad_width
    $error("traffic_ctrl_multi: CNT_W too small for green + extension budget");
  end

  phase_t           phase_q, phase_d;
  logic             blink_q, blink_d;
  logic [CNT_W-1:0] ext_used_q, ext_used_d;
  logic [CNT_W-1:0] budget, grant, load_val;
  logic             ext_ok, load, ext_add, timer_zero;
  lamp_pair_t       lamps_q;

  function automatic logic [CNT_W-1:0] dur_m1(phase_t p);
    case (p)
      NS_GREEN:            return CNT_W'(GREEN_NS - 1);
      EW_GREEN:            return CNT_W'(GREEN_EW - 1);
      NS_YELLOW, EW_YELLOW: return CNT_W'(YELLOW - 1);
      default:             return CNT_W'(ALL_RED - 1);
    endcase
  endfunction

  always_comb begin
    budget = CNT_W'(EXT_MAX) - ext_used_q;
    grant  = (budget < CNT_W'(EXT_STEP)) ? budget : CNT_W'(EXT_STEP);
    ext_ok = (ext_used_q < CNT_W'(EXT_MAX)) &&
             ((phase_q == NS_GREEN && ns_ext) || (phase_q == EW_GREEN && ew_ext));

    phase_d    = phase_q;
    blink_d    = blink_q;
    ext_used_d = ext_used_q;
    load       = 1'b0;
    load_val   = '0;
    ext_add    = 1'b0;

    // Priority: flash > leaving flash > extension > expiry > count down.
    if (flash_req) begin
      phase_d = FLASH;
      blink_d = (phase_q == FLASH) ? ~blink_q : 1'b1;
      load    = 1'b1;
    end else if (phase_q == FLASH) begin
      phase_d  = RED_B;
      blink_d  = 1'b0;
      load     = 1'b1;
      load_val = CNT_W'(ALL_RED - 1);
    end else if (ext_ok) begin
      ext_add    = 1'b1;
      ext_used_d = ext_used_q + grant;
    end else if (timer_zero) begin
      phase_d  = next_phase(phase_q);
      load     = 1'b1;
      load_val = dur_m1(phase_d);
      if (phase_d == NS_GREEN || phase_d == EW_GREEN)
        ext_used_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q     <= NS_GREEN;
      blink_q     <= 1'b0;
      ext_used_q  <= '0;
      lamps_q     <= decode_lamps(NS_GREEN, 1'b0);
      cycle_start <= 1'b0;
    end else begin
      cycle_start <= 1'b0;
      if (tick) begin
        phase_q     <= phase_d;
        blink_q     <= blink_d;
        ext_used_q  <= ext_used_d;
        lamps_q     <= decode_lamps(phase_d, blink_d);
        cycle_start <= (phase_d == NS_GREEN) && (phase_q != NS_GREEN);
      end
    end
  end

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (CNT_W'(GREEN_NS - 1))
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .load     (load),
    .load_val (load_val),
    .ext      (ext_add),
    .grant    (grant),
    .timer    (timer),
    .zero     (timer_zero)
  );

  assign phase     = phase_q;
  assign ns_green  = lamps_q.ns.green;
  assign ns_yellow = lamps_q.ns.yellow;
  assign ns_red    = lamps_q.ns.red;
  assign ew_green  = lamps_q.ew.green;
  assign ew_yellow = lamps_q.ew.yellow;
  assign ew_red    = lamps_q.ew.red;

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Testbench for traffic_ctrl_multi: directed scenarios followed by random
// stimulus, all compared against a remaining-ticks reference model.
module tb_traffic_ctrl_multi;

  localparam int CNT_W    = 8;
  localparam int GREEN_NS = 10;
  localparam int GREEN_EW = 10;
  localparam int YELLOW   = 3;
  localparam int ALL_RED  = 1;
  localparam int EXT_STEP = 5;
  localparam int EXT_MAX  = 10;

  logic clk = 1'b0;
  logic reset, tick, ns_ext, ew_ext, flash_req;
  logic ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red;
  logic [2:0] phase;
  logic [CNT_W-1:0] timer;
  logic cycle_start;

  int checks = 0;
  int errors = 0;

  // Reference model: phase number, ticks left in phase, extension used.
  int m_phase, m_rem, m_used;
  bit m_blink, m_cs;

  always #5 clk = ~clk;

  traffic_ctrl_multi #(
    .CNT_W(CNT_W), .GREEN_NS(GREEN_NS), .GREEN_EW(GREEN_EW), .YELLOW(YELLOW),
    .ALL_RED(ALL_RED), .EXT_STEP(EXT_STEP), .EXT_MAX(EXT_MAX)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .ns_ext(ns_ext), .ew_ext(ew_ext),
    .flash_req(flash_req), .ns_green(ns_green), .ns_yellow(ns_yellow),
    .ns_red(ns_red), .ew_green(ew_green), .ew_yellow(ew_yellow), .ew_red(ew_red),
    .phase(phase), .timer(timer), .cycle_start(cycle_start)
  );

  function automatic int dur(input int p);
    case (p)
      0: return GREEN_NS;
      3: return GREEN_EW;
      1, 4: return YELLOW;
      default: return ALL_RED;
    endcase
  endfunction

  // Lamps as {ns g,y,r, ew g,y,r}.
  function automatic logic [5:0] exp_lamps(input int p, input bit b);
    case (p)
      0: return 6'b100_001;
      1: return 6'b010_001;
      3: return 6'b001_100;
      4: return 6'b001_010;
      6: return {1'b0, b, 1'b0, 1'b0, 1'b0, b};
      default: return 6'b001_001;
    endcase
  endfunction

  task automatic m_reset();
    m_phase = 0; m_rem = GREEN_NS; m_used = 0; m_blink = 0; m_cs = 0;
  endtask

  task automatic m_tick(input bit n, input bit e, input bit f);
    int g;
    m_cs = 0;
    if (f) begin
      m_blink = (m_phase == 6) ? !m_blink : 1'b1;
      m_phase = 6;
      m_rem   = 1;
    end else if (m_phase == 6) begin
      m_phase = 5; m_rem = ALL_RED; m_blink = 0;
    end else if (((m_phase == 0 && n) || (m_phase == 3 && e)) && m_used < EXT_MAX) begin
      g = (EXT_MAX - m_used < EXT_STEP) ? EXT_MAX - m_used : EXT_STEP;
      m_used += g;
      m_rem   = m_rem - 1 + g;
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        m_phase = (m_phase + 1) % 6;
        m_rem   = dur(m_phase);
        if (m_phase == 0 || m_phase == 3) m_used = 0;
        m_cs = (m_phase == 0);
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [5:0] l;
    l = {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red};
    check("phase", 32'(phase), 32'(m_phase));
    check("timer", 32'(timer), 32'(m_rem - 1));
    check("lamps", 32'(l), 32'(exp_lamps(m_phase, m_blink)));
    check("cycle_start", 32'(cycle_start), 32'(m_cs));
    if (m_phase != 6) begin
      check("one_ns_lamp", 32'($countones(l[5:3])), 32'd1);
      check("one_ew_lamp", 32'($countones(l[2:0])), 32'd1);
    end
  endtask

  task automatic step(input bit t, input bit n, input bit e, input bit f);
    @(negedge clk);
    tick = t; ns_ext = n; ew_ext = e; flash_req = f;
    @(posedge clk);
    #1;
    if (t) m_tick(n, e, f);
    else   m_cs = 0;
    check_all();
  endtask

  task automatic run_to(input int ph, input int tm);
    int k = 0;
    while (!(m_phase == ph && (tm < 0 || m_rem - 1 == tm)) && k < 200) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      k++;
    end
    check("run_to_phase", 32'(phase), 32'(ph));
  endtask

  initial begin
    int k;
    bit ext_done;
    int flash_hold;

    reset = 1'b1; tick = 1'b0; ns_ext = 1'b0; ew_ext = 1'b0; flash_req = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all();

    // One full default cycle, no requests.
    for (int i = 0; i < 28; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("cycle_end_phase", 32'(phase), 32'd0);
    check("cycle_end_pulse", 32'(cycle_start), 32'd1);

    // NS extensions on ticks 2 and 9; tick 15 finds the budget spent.
    k = 0;
    do begin
      k++;
      step(1'b1, (k == 2 || k == 9 || k == 15), 1'b0, 1'b0);
    end while (phase == 3'd0 && k < 60);
    check("ns_green_len", 32'(k), 32'd20);
    run_to(3, -1);
    k = 0;
    do begin
      k++;
      step(1'b1, 1'b0, 1'b0, 1'b0);
    end while (phase == 3'd3 && k < 60);
    check("ew_green_len", 32'(k), 32'd10);

    // EW extension on the same tick as expiry keeps the phase green.
    run_to(3, -1);
    k = 0;
    ext_done = 0;
    do begin
      k++;
      step(1'b1, 1'b0, (m_rem == 1 && !ext_done), 1'b0);
      if (k == 10) ext_done = 1;
    end while (phase == 3'd3 && k < 60);
    check("ew_green_ext_len", 32'(k), 32'd15);

    // Flash entered from EW_GREEN at timer=4, blink pattern, then exit.
    run_to(3, 4);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1);
      check("flash_phase", 32'(phase), 32'd6);
      check("flash_ns_yellow", 32'(ns_yellow), 32'((i % 2) == 0));
      check("flash_ew_red", 32'(ew_red), 32'((i % 2) == 0));
      check("flash_timer", 32'(timer), 32'd0);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("flash_exit_phase", 32'(phase), 32'd5);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("post_flash_phase", 32'(phase), 32'd0);
    check("post_flash_timer", 32'(timer), 32'd9);
    check("post_flash_pulse", 32'(cycle_start), 32'd1);

    // Asynchronous reset in the middle of NS_YELLOW.
    run_to(1, -1);
    @(negedge clk);
    tick = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    m_reset();
    check("async_rst_phase", 32'(phase), 32'd0);
    check("async_rst_timer", 32'(timer), 32'(GREEN_NS - 1));
    check("async_rst_lamps",
          32'({ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red}), 32'b100_001);
    #2 reset = 1'b0;

    // No tick for 50 clocks: requests must have no effect.
    for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    check("hold_phase", 32'(phase), 32'd0);
    check("hold_timer", 32'(timer), 32'(GREEN_NS - 1));

    // Random traffic: sparse ticks, random requests, occasional flash bursts.
    flash_hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (flash_hold > 0) flash_hold--;
      else if ($urandom_range(0, 59) == 0) flash_hold = $urandom_range(1, 6);
      step($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), flash_hold > 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
